// File: rtl/payload_read_arbiter.sv
// Round-robin arbiter sharing the PayloadBuffer read port between NUM_REQ requesters.
// Optional per-requester saturating packet counters: define PAYLOAD_READ_ARB_STATS_EN.
module payload_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 2048,
    parameter int MAX_WORDS   = 512,
    parameter int STAT_WIDTH  = 16,
    localparam int AW         = $clog2(BUFFER_SIZE),
    localparam int CHW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*AW-1:0]         req_address,
    input  logic [NUM_REQ-1:0]            req_destructive,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         src_data,
    output logic [NUM_REQ-1:0]            src_valid,
    input  logic [NUM_REQ-1:0]            src_ready,
    output logic                          src_startofpacket,
    output logic                          src_endofpacket,
    output logic [CHW-1:0]                src_channel,
    input  logic                          pb_ready,
    output logic                          pb_rd_enable,
    output logic                          pb_rd_first,
    output logic [AW-1:0]                 pb_rd_address,
    output logic                          pb_rd_destructive,
    input  logic [DATA_WIDTH-1:0]         pb_rd_data,
    input  logic                          pb_rd_last,
    output logic                          busy,
`ifdef PAYLOAD_READ_ARB_STATS_EN
    output logic [NUM_REQ*STAT_WIDTH-1:0] pkt_count,
`endif
    output logic                          err_overrun
);

    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StAddr, StStream} state_e;

    state_e          r_state;
    logic [CHW-1:0]  r_grant;
    logic [CHW-1:0]  r_rr_last;
    logic [AW-1:0]   r_address;
    logic            r_destructive;
    logic            r_sop;
    logic [CW-1:0]   r_word_cnt;
    logic            r_err_overrun;

    logic            w_found;
    logic [CHW-1:0]  w_winner;
    logic            w_grant;
    logic            w_accept;
    logic            w_forced;
    logic            w_eop;

    // Scan upward from the requester after the last one served.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_last) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = CHW'((int'(r_rr_last) + k) % NUM_REQ);
            end
        end
    end

    // reset_n gates the grant so req_ready stays low while reset is asserted.
    assign w_grant  = reset_n && (r_state == StIdle) && pb_ready && w_found;
    assign w_accept = (r_state == StStream) && src_ready[r_grant];
    assign w_forced = (r_word_cnt == CW'(MAX_WORDS - 1));
    assign w_eop    = pb_rd_last || w_forced;

    always_comb begin
        req_ready         = '0;
        src_valid         = '0;
        pb_rd_enable      = 1'b0;
        pb_rd_first       = 1'b0;
        src_startofpacket = 1'b0;
        src_endofpacket   = 1'b0;
        if (w_grant) begin
            req_ready[w_winner] = 1'b1;
        end
        unique case (r_state)
            StAddr: begin
                pb_rd_enable = 1'b1;
                pb_rd_first  = 1'b1;
            end
            StStream: begin
                src_valid[r_grant] = 1'b1;
                src_startofpacket  = r_sop;
                src_endofpacket    = w_eop;
                pb_rd_enable       = src_ready[r_grant];
            end
            default: ;
        endcase
    end

    assign src_data          = pb_rd_data;
    assign src_channel       = r_grant;
    assign pb_rd_address     = r_address;
    assign pb_rd_destructive = r_destructive;
    assign busy              = (r_state != StIdle);
    assign err_overrun       = r_err_overrun;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_grant       <= '0;
            r_rr_last     <= CHW'(NUM_REQ - 1);
            r_address     <= '0;
            r_destructive <= 1'b0;
            r_sop         <= 1'b0;
            r_word_cnt    <= '0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_overrun <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_grant) begin
                        r_grant       <= w_winner;
                        r_address     <= req_address[w_winner*AW +: AW];
                        r_destructive <= req_destructive[w_winner];
                        r_word_cnt    <= '0;
                        r_sop         <= 1'b1;
                        r_state       <= StAddr;
                    end
                end
                StAddr: r_state <= StStream;
                StStream: begin
                    if (w_accept) begin
                        r_sop <= 1'b0;
                        if (r_word_cnt != CW'(MAX_WORDS)) begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                        if (w_eop) begin
                            r_state       <= StIdle;
                            r_rr_last     <= r_grant;
                            r_err_overrun <= w_forced && !pb_rd_last;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef PAYLOAD_READ_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] r_pkt_cnt [NUM_REQ];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else if (w_accept && w_eop && (r_pkt_cnt[r_grant] != '1)) begin
            r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pkt_count
        assign pkt_count[i*STAT_WIDTH +: STAT_WIDTH] = r_pkt_cnt[i];
    end
`endif

endmodule

// File: tb/tb_payload_read_arbiter.sv
// Self-checking bench for payload_read_arbiter with a behavioural PayloadBuffer model.
// Exercises pkt_count too when PAYLOAD_READ_ARB_STATS_EN is defined.
module tb_payload_read_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int BS  = 2048;
    localparam int AW  = 11;
    localparam int MW  = 4;
    localparam int SW  = 2;
    localparam int CHW = 2;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b1;
    logic [N-1:0]      req_valid, req_destructive, req_ready, src_valid, src_ready;
    logic [N*AW-1:0]   req_address;
    logic [DW-1:0]     src_data, pb_rd_data;
    logic              src_startofpacket, src_endofpacket;
    logic [CHW-1:0]    src_channel;
    logic              pb_ready, pb_rd_enable, pb_rd_first, pb_rd_destructive, pb_rd_last;
    logic              busy, err_overrun;
    logic [AW-1:0]     pb_rd_address;
`ifdef PAYLOAD_READ_ARB_STATS_EN
    logic [N*SW-1:0]   pkt_count;
`endif

    int             n_chk = 0;
    int             n_fail = 0;
    int             exp_last;
    int             exp_cnt [N];
    logic           exp_ovr;
    logic           hold;
    logic [AW-1:0]  addr_tab [N];
    logic [N-1:0]   dest_tab;
    logic [DW-1:0]  seed;
    int             pb_len;
    logic [AW-1:0]  pb_addr_q;
    int             pb_idx;
    int             g;

    payload_read_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BUFFER_SIZE(BS),
        .MAX_WORDS  (MW),
        .STAT_WIDTH (SW)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_address      (req_address),
        .req_destructive  (req_destructive),
        .req_ready        (req_ready),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .src_startofpacket(src_startofpacket),
        .src_endofpacket  (src_endofpacket),
        .src_channel      (src_channel),
        .pb_ready         (pb_ready),
        .pb_rd_enable     (pb_rd_enable),
        .pb_rd_first      (pb_rd_first),
        .pb_rd_address    (pb_rd_address),
        .pb_rd_destructive(pb_rd_destructive),
        .pb_rd_data       (pb_rd_data),
        .pb_rd_last       (pb_rd_last),
        .busy             (busy),
`ifdef PAYLOAD_READ_ARB_STATS_EN
        .pkt_count        (pkt_count),
`endif
        .err_overrun      (err_overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a, input int i);
        return seed ^ {5'd0, a, i[15:0]};
    endfunction

    // PayloadBuffer: packet at the sampled address is pb_len words long.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pb_idx <= 0;
        end else if (pb_rd_enable) begin
            if (pb_rd_first) begin
                pb_addr_q <= pb_rd_address;
                pb_idx    <= 0;
            end else begin
                pb_idx <= pb_idx + 1;
            end
        end
    end
    assign pb_rd_data = word_of(pb_addr_q, pb_idx);
    assign pb_rd_last = (pb_idx == pb_len - 1);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic drive_addrs();
        for (int i = 0; i < N; i++) begin
            req_address[i*AW +: AW] = addr_tab[i];
        end
        req_destructive = dest_tab;
    endtask

    function automatic int exp_winner();
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(exp_last + k) % N]) return (exp_last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*SW-1:0] pack_cnt();
        logic [N*SW-1:0] p;
        for (int i = 0; i < N; i++) p[i*SW +: SW] = SW'(exp_cnt[i]);
        return p;
    endfunction

    // One full transfer, starting in the grant cycle; mode 0 random stalls, 1 none, 2 (1,0,0,1).
    task automatic serve(input int len, input int mode);
        int           w;
        int           nw;
        int           stalls;
        logic [N-1:0] onehot;
        w      = exp_winner();
        onehot = N'(1) << w;
        pb_len = len;
        nw     = (len < MW) ? len : MW;
        sample();
        chk("req_ready_grant", 64'(req_ready), 64'(onehot));
        chk("busy_at_grant", 64'(busy), 64'd0);
        chk("overrun_flag", 64'(err_overrun), 64'(exp_ovr));
        exp_ovr = 1'b0;
        tick();
        if (!hold) req_valid[w] = 1'b0;
        src_ready = N'($urandom) & ~onehot;
        sample();
        chk("addr_stage", 64'({pb_rd_enable, pb_rd_first}), 64'd3);
        chk("rd_address", 64'(pb_rd_address), 64'(addr_tab[w]));
        chk("rd_destructive", 64'(pb_rd_destructive), 64'(dest_tab[w]));
        chk("addr_quiet", 64'({req_ready, src_valid, busy}), 64'd1);
        chk("overrun_once", 64'(err_overrun), 64'd0);
        for (int i = 0; i < nw; i++) begin
            stalls = (mode == 0) ? int'($urandom_range(0, 2)) : ((mode == 2 && i == 1) ? 2 : 0);
            for (int s = 0; s <= stalls; s++) begin
                tick();
                src_ready = (N'($urandom) & ~onehot) | ((s == stalls) ? onehot : N'(0));
                pb_ready  = (mode == 0) ? 1'($urandom) : 1'b1;
                sample();
                chk("src_valid", 64'(src_valid), 64'(onehot));
                chk("src_channel", 64'(src_channel), 64'(w));
                chk("src_data", 64'(src_data), 64'(word_of(addr_tab[w], i)));
                chk("sop", 64'(src_startofpacket), 64'(i == 0));
                chk("eop", 64'(src_endofpacket), 64'(i == nw - 1));
                chk("rd_enable", 64'({pb_rd_enable, pb_rd_first}), 64'((s == stalls) ? 2 : 0));
                chk("req_ready_busy", 64'(req_ready), 64'd0);
            end
        end
        tick();
        src_ready = '0;
        pb_ready  = 1'b1;
        exp_last  = w;
        exp_ovr   = (len > MW);
        if (exp_cnt[w] < (1 << SW) - 1) exp_cnt[w]++;
    endtask

    task automatic idle_check();
        sample();
        chk("idle_quiet", 64'({busy, src_valid, req_ready, pb_rd_enable}), 64'd0);
        chk("overrun_flag", 64'(err_overrun), 64'(exp_ovr));
        exp_ovr = 1'b0;
`ifdef PAYLOAD_READ_ARB_STATS_EN
        chk("pkt_count", 64'(pkt_count), 64'(pack_cnt()));
`endif
        tick();
    endtask

    initial begin
        req_valid = '0;
        req_address = '0;
        req_destructive = '0;
        src_ready = '0;
        pb_ready = 1'b1;
        pb_len = 1;
        seed = $urandom;
        hold = 1'b0;
        exp_ovr = 1'b0;
        exp_last = N - 1;
        for (int i = 0; i < N; i++) begin
            exp_cnt[i]  = 0;
            addr_tab[i] = AW'($urandom);
            dest_tab[i] = 1'($urandom);
        end
        addr_tab[0] = 11'h010;
        drive_addrs();
        req_valid = '1;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_outputs", 64'({pb_rd_enable, pb_rd_first, src_valid, req_ready, busy,
                                  err_overrun, src_startofpacket, src_channel}), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Single 3-word packet from requester 0 at 0x010.
        req_valid = 4'b0001;
        serve(3, 1);
        idle_check();

        // Round-robin with all requests held.
        for (int i = 0; i < N; i++) addr_tab[i] = AW'($urandom);
        drive_addrs();
        hold = 1'b1;
        req_valid = '1;
        for (int p = 0; p < 5; p++) serve(int'($urandom_range(1, 3)), 0);
        req_valid = '0;
        hold = 1'b0;
        idle_check();

        // Backpressure pattern 1,0,0,1.
        req_valid = 4'b0100;
        serve(3, 2);
        idle_check();

        // Overrun: buffer never signals last.
        req_valid = 4'b1000;
        serve(7, 1);
        idle_check();
        idle_check();

        // pb_ready gating, then reset mid-stream.
        pb_ready = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("gated", 64'({req_ready, busy}), 64'd0);
            tick();
        end
        pb_ready = 1'b1;
        g = exp_winner();
        pb_len = 5;
        sample();
        chk("regrant", 64'(req_ready), 64'(N'(1) << g));
        tick();
        req_valid = '0;
        tick();
        src_ready = '1;
        sample();
        chk("mid_stream", 64'(src_valid), 64'(N'(1) << g));
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async", 64'({pb_rd_enable, pb_rd_first, src_valid, req_ready, busy,
                              err_overrun, src_startofpacket, src_channel}), 64'd0);
        tick();
        sample();
        chk("rst_hold", 64'({pb_rd_enable, src_valid, busy}), 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        src_ready = '0;
        exp_last = N - 1;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        req_valid = '1;
        g = exp_winner();
        chk("first_after_reset", 64'(g), 64'd0);
        req_valid = 4'b0001;
        serve(2, 0);
        idle_check();

        // Five packets to requester 1.
        hold = 1'b1;
        req_valid = 4'b0010;
        for (int p = 0; p < 5; p++) serve(1, 0);
        req_valid = '0;
        hold = 1'b0;
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/payload_read_arbiter.md
Name: payload_read_arbiter

Overview:
- Shares the single PayloadBuffer read port between NUM_REQ requesters (dispatcher egress lanes).
- Each requester submits a read request with an address and a destructive flag. The block grants requests round-robin and drives the PayloadBuffer two-phase read protocol (address stage, then data stage).
- Returns the packet words to the granted requester on a shared Avalon-ST source, with a per-requester one-hot valid and ready.
- Sits between the egress schedulers and the PayloadBuffer, replacing direct single-master access to the read port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload word width.
- BUFFER_SIZE, 2048, buffer depth in words. AW = $clog2(BUFFER_SIZE).
- MAX_WORDS, 512, maximum words per packet before the overrun guard trips.
- STAT_WIDTH, 16, width of each packet counter (optional feature only).

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  read request pending, one bit per requester.
- req_address  in  NUM_REQ*AW  packet head address. Requester i uses bits [i*AW +: AW].
- req_destructive  in  NUM_REQ  free the packet after the read.
- req_ready  out  NUM_REQ  request accepted (one-hot).
- src_data  out  DATA_WIDTH  packet word.
- src_valid  out  NUM_REQ  one-hot word valid for the granted requester.
- src_ready  in  NUM_REQ  per-requester ready.
- src_startofpacket  out  1  first word of packet.
- src_endofpacket  out  1  last word of packet.
- src_channel  out  max(1,$clog2(NUM_REQ))  index of the granted requester.
- pb_ready  in  1  PayloadBuffer ready.
- pb_rd_enable  out  1  PayloadBuffer read enable.
- pb_rd_first  out  1  address stage strobe.
- pb_rd_address  out  AW  head address.
- pb_rd_destructive  out  1  destructive read.
- pb_rd_data  in  DATA_WIDTH  current word.
- pb_rd_last  in  1  current word is the last.
- busy  out  1  a transfer is in progress (state != IDLE).
- err_overrun  out  1  one-cycle pulse when the MAX_WORDS guard trips.

Behaviour:
- Reset: asynchronous on reset_n low.
  - State -> IDLE.
  - Outputs: pb_rd_enable, pb_rd_first, src_valid, req_ready, busy, err_overrun, src_startofpacket = 0; src_channel = 0.
  - rr_last = NUM_REQ-1, so the first grant goes to requester 0.
  - Reset mid-packet abandons the PayloadBuffer read with no further pb_rd_enable.
- PayloadBuffer protocol:
  - Cycle with pb_rd_enable=1 and pb_rd_first=1: pb_rd_address is sampled.
  - Following cycles: pb_rd_data / pb_rd_last show the current word.
  - pb_rd_enable=1 with pb_rd_first=0 consumes the current word and advances to the next.
- FSM states: IDLE, ADDR, STREAM.
- IDLE:
  - Grant happens only when pb_ready=1 and some req_valid is set.
  - Winner = first set req_valid scanning from rr_last+1 upward, modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in this cycle. No other req_ready bit is high.
  - Registered on grant: grant index, address, destructive flag, word_cnt=0, sop_flag=1.
  - Next state -> ADDR.
  - When pb_ready=0, req_ready stays 0.
- ADDR (exactly 1 cycle, independent of src_ready):
  - pb_rd_enable=1, pb_rd_first=1, pb_rd_address/pb_rd_destructive = latched values.
  - Next state -> STREAM.
- STREAM:
  - src_valid[g]=1, src_data=pb_rd_data, src_channel=g, src_startofpacket=sop_flag.
  - src_endofpacket = pb_rd_last OR (word_cnt == MAX_WORDS-1).
  - pb_rd_enable = src_ready[g], pb_rd_first=0.
  - On accept (src_ready[g]=1): word_cnt++, sop_flag=0.
  - Accept with src_endofpacket=1: next state IDLE, rr_last=g.
  - If that end was forced by the guard while pb_rd_last=0, err_overrun pulses in the following cycle.
- Grant latency: request accepted in cycle T; ADDR at T+1; first word visible at T+2.
- Back-to-back: next grant is evaluated in the IDLE cycle after the last accept, giving a 2-cycle gap between packets.
- Handshake rules:
  - req_valid must be held until accepted.
  - src_ready of non-granted requesters is ignored.
  - src_valid is never asserted outside STREAM.
- Single-word packet: pb_rd_last=1 on the first word, so SOP and EOP are asserted together.
- pb_ready dropping during ADDR/STREAM has no effect; it gates new grants only.
- word_cnt width = $clog2(MAX_WORDS+1); it never wraps.

Optional Feature:
- Macro: PAYLOAD_READ_ARB_STATS_EN.
- Defined:
  - Adds output port pkt_count (NUM_REQ*STAT_WIDTH).
  - One saturating counter per requester increments on each EOP accept for that requester.
  - Counters reset to 0 by reset_n and stick at all-ones.
- Undefined: no port, no counters. All other behaviour is identical.

Test Plan:
- Single request: req_valid=4'b0001, address=0x010; PayloadBuffer returns 3 words with last on the 3rd -> req_ready[0] at T, pb_rd_first and address 0x010 at T+1, src_valid=4'b0001 for 3 accepts, SOP on word 1, EOP on word 3, busy low after.
- Round-robin: req_valid=4'b1111 held -> grant order 0,1,2,3,0; src_channel matches each; no req_ready while busy.
- Backpressure: src_ready[g] toggled 1,0,0,1 during STREAM -> pb_rd_enable follows src_ready exactly; src_data stable while stalled; no word lost or duplicated.
- Overrun: MAX_WORDS=4, PayloadBuffer never asserts last -> EOP forced on word 4, err_overrun pulses once, FSM returns to IDLE.
- Gating/reset: pb_ready=0 with req_valid=1 -> no req_ready. Then reset_n low mid-STREAM -> all outputs 0 immediately; after release, the next grant goes to requester 0.
- With PAYLOAD_READ_ARB_STATS_EN, STAT_WIDTH=2: 5 packets to requester 1 -> pkt_count[1] saturates at 3; other counters stay 0.
